reg_writeback: RTL
==================

Name: reg_writeback

Overview:
- Write-back stage that drives the register file write port (reg_write, rd_addr, write_data) from two sources: single-cycle ALU results, and load responses from data memory.
- Tracks one outstanding load with a busy scoreboard so younger consumers and writers can be held off.
- Aligns and sign-extends load data.
- Supplies same-cycle bypass data for the register file read ports, because the register file reads combinationally and writes at the clock edge.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; register address width is $clog2(NREG).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_issue  in  1  load issued to memory.
- ld_issue_ready  out  1  load slot free.
- ld_rd  in  5  load destination register.
- ld_funct3  in  3  load type.
- ld_byte_off  in  2  address bits [1:0].
- mem_rsp_valid  in  1  memory read data valid.
- mem_rsp_ready  out  1  block can take the response.
- mem_rsp_data  in  XLEN  word-aligned read data.
- reg_write  out  1  register file write enable.
- rd_addr  out  5  register file write address.
- write_data  out  XLEN  register file write data.
- rs1_addr, rs2_addr  in  5 each  read addresses, snooped from the register file read ports.
- rs1_busy, rs2_busy  out  1 each  the source register is a pending load destination.
- rs1_fwd_en, rs2_fwd_en  out  1 each  use the forwarded value instead of the register file value.
- rs1_fwd_data, rs2_fwd_data  out  XLEN each  forwarded value.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - Reset is asynchronous and active-high, named reset.
- Reset values:
  - reg_write=0, rd_addr=0, write_data=0.
  - State IDLE; busy vector all 0; load buffer 0.
  - Consequently ld_issue_ready=1, mem_rsp_ready=0, alu_ready=1.
- Output register: reg_write, rd_addr and write_data are registered. Latency from accept to write strobe is 1 cycle.
- FSM states are IDLE, WAIT_RSP and WRITE.
- IDLE:
  - ld_issue_ready=1.
  - On ld_issue: capture ld_rd, funct3 and byte_off; set busy[ld_rd] if ld_rd!=0; go to WAIT_RSP.
- WAIT_RSP:
  - mem_rsp_ready=1.
  - On mem_rsp_valid, capture the extended data into the buffer and go to WRITE.
- WRITE:
  - alu_ready=0.
  - Next edge: output regs take the buffered load with reg_write=(ld_rd!=0); busy[ld_rd] clears; go to IDLE.
  - Load write-back therefore has priority and cannot starve.
- alu_ready is 0 in WRITE, or when alu_rd equals a pending load rd (alu_rd!=0, WAW hold). Otherwise alu_ready=1.
- ALU accept:
  - Next cycle, reg_write=(alu_rd!=0), rd_addr=alu_rd, write_data=alu_data.
  - If nothing is accepted, reg_write=0 next cycle; rd_addr and write_data hold.
- Simultaneous events:
  - ALU accept and memory response in the same cycle: the ALU result goes to the output regs, the load goes to the buffer, and the load is written one cycle later.
  - ld_issue in WAIT_RSP or WRITE is ignored; the issuer must honour ld_issue_ready.
- Load extension from lane byte_off:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword from lane {byte_off[1],0}.
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extend.
  - Other funct3 values: full word.
- Hazard outputs:
  - rsN_busy = busy[rsN_addr], combinational. busy[0] is always 0.
- Forwarding:
  - rsN_fwd_en = reg_write && rd_addr==rsN_addr && rd_addr!=0.
  - rsN_fwd_data = write_data.
- x0: never written and never marked busy. A load to x0 still completes its handshake.
- Reset mid-load: the FSM returns to IDLE and busy clears. A later stray mem_rsp_valid is ignored because mem_rsp_ready=0.

Decomposition:
- Shared package riscv_pkg holds:
  - load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - typedef enum wb_state_t {IDLE, WAIT_RSP, WRITE};
  - REG_ADDR_W.
- One combinational sub-module, load_align: inputs funct3, byte_off, word; output extended XLEN value.

Test Plan:
- Reset, then ALU accept rd=5, data 0x1234_5678: next cycle reg_write=1, rd_addr=5, write_data=0x12345678. rs1_addr=5 in that cycle gives rs1_fwd_en=1 and rs1_fwd_data=0x12345678.
- ALU accept with rd=0, data 0xFFFF_FFFF: reg_write stays 0, no forward.
- Load path:
  - ld_issue rd=7, funct3=LB, off=2: rs2_addr=7 gives rs2_busy=1.
  - Response 0x0080_0000: write x7=0xFFFF_FF80; busy clears the same edge.
  - Repeat with LHU, off=2, data 0x8001_0000: write 0x0000_8001.
- WAW hold: load rd=9 pending, alu_valid with rd=9: alu_ready=0 until the load write-back cycle, then the ALU result is written one cycle after the load.
- Collision: in WAIT_RSP, ALU rd=3 and mem response (LW 0xDEAD_BEEF, rd=4) arrive in the same cycle: cycle+1 writes x3, cycle+2 writes x4=0xDEADBEEF; alu_ready=0 during the WRITE state.
- Assert reset in WAIT_RSP: busy all 0, ld_issue_ready=1. A stray mem_rsp_valid afterwards produces no write.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared load encodings, write-back states and register address width.
package riscv_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT_RSP, WRITE} wb_state_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword lane of a loaded word and extends it.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] ext
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word[{byte_off, 3'b000} +: 8];
  assign h = word[{byte_off[1], 4'b0000} +: 16];
  always_comb begin
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){b[7]}}, b};
      F3_LH:   ext = {{(XLEN-16){h[15]}}, h};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, h};
      default: ext = word;
    endcase
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: register-file write port arbiter for ALU results and one outstanding load,
// with a busy scoreboard for the pending load and same-cycle bypass of the registered write.
module reg_writeback
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_issue,
  output logic                  ld_issue_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [2:0]            ld_funct3,
  input  logic [1:0]            ld_byte_off,
  input  logic                  mem_rsp_valid,
  output logic                  mem_rsp_ready,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       write_data,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rs1_fwd_en,
  output logic                  rs2_fwd_en,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic [XLEN-1:0]       rs2_fwd_data
);
  wb_state_t             state_q, state_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d, rd_q, rd_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic [XLEN-1:0]       buf_q, buf_d, wd_q, wd_d, ext;
  logic                  we_q, we_d, alu_acc;
  load_align #(.XLEN(XLEN)) u_align (
    .funct3  (f3_q),
    .byte_off(off_q),
    .word    (mem_rsp_data),
    .ext     (ext)
  );
  assign ld_issue_ready = state_q == IDLE;
  assign mem_rsp_ready  = state_q == WAIT_RSP;
  // Hold an ALU write to the pending load's rd so the older load cannot overwrite it.
  assign alu_ready      = state_q != WRITE && !(alu_rd != '0 && busy_q[alu_rd]);
  assign alu_acc        = alu_valid && alu_ready;
  assign reg_write      = we_q;
  assign rd_addr        = rd_q;
  assign write_data     = wd_q;
  assign rs1_busy       = busy_q[rs1_addr];
  assign rs2_busy       = busy_q[rs2_addr];
  assign rs1_fwd_en     = we_q && rd_q == rs1_addr && rd_q != '0;
  assign rs2_fwd_en     = we_q && rd_q == rs2_addr && rd_q != '0;
  assign rs1_fwd_data   = wd_q;
  assign rs2_fwd_data   = wd_q;
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    ld_rd_d = ld_rd_q;
    f3_d    = f3_q;
    off_d   = off_q;
    buf_d   = buf_q;
    we_d    = alu_acc && alu_rd != '0;
    rd_d    = alu_acc ? alu_rd : rd_q;
    wd_d    = alu_acc ? alu_data : wd_q;
    case (state_q)
      IDLE: if (ld_issue) begin
        state_d        = WAIT_RSP;
        ld_rd_d        = ld_rd;
        f3_d           = ld_funct3;
        off_d          = ld_byte_off;
        busy_d[ld_rd]  = ld_rd != '0;
      end
      WAIT_RSP: if (mem_rsp_valid) begin
        state_d = WRITE;
        buf_d   = ext;
      end
      WRITE: begin
        state_d         = IDLE;
        we_d            = ld_rd_q != '0;
        rd_d            = ld_rd_q;
        wd_d            = buf_q;
        busy_d[ld_rd_q] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= '0;
      ld_rd_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      buf_q   <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ld_rd_q <= ld_rd_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      buf_q   <= buf_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
    end
  end
endmodule
